// File: rtl/fifo_pkg.sv
// Purpose : shared helpers for the FIFO family (ceiling-log2, pointer wrap).
// Latency : n/a (constant and combinational functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Ceiling log2, used for count and pointer widths (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Advance a pointer by one, wrapping to 0 after depth-1 by explicit
    // compare so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sync_ext_if.sv
// Purpose : handshake/data bundle between a producer/consumer and fifo_sync_ext.
// Latency : n/a (wires only).
// Backpressure: producer watches full, consumer watches empty.
// Ports   : wr_en/rd_en/din towards the FIFO; dout, full, empty, almost_full,
//           almost_empty, count, overflow, underflow back from it.
interface fifo_sync_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
);
    import fifo_pkg::*;

    localparam int CW = clog2(MEM_DEPTH + 1);

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, din,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, din,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Purpose : simple dual-port memory, one write port, one read port with registered output.
// Latency : 1 cycle read (rdata updates on the edge where re is high).
// Backpressure: none; caller gates we/re. rdata holds when re is low.
// Ports   : clk, rst (async, resets rdata only), we/waddr/wdata, re/raddr, rdata.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // A read of the address being written on the same edge returns the old word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fifo_sync_ext.sv
// Purpose : single-clock FIFO, any depth >= 2, occupancy count, almost-full/empty thresholds.
// Latency : 1-cycle registered read; a write is readable from the following edge.
// Backpressure: write dropped when full unless a read happens on the same edge; read ignored when empty.
// Ports   : clk, rst (async active-high), bus (fifo_sync_ext_if.slave).
// Option  : define FIFO_SYNC_ERR_FLAGS_EN for sticky overflow/underflow; otherwise both read 0.
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int AF_LEVEL   = MEM_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fifo_sync_ext_if.slave bus
);
    localparam int CW = clog2(MEM_DEPTH + 1);
    localparam int PW = clog2(MEM_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          wr_acc;
    logic          rd_acc;

    always_comb begin
        // When full, a simultaneous read frees the slot the write lands in.
        wr_acc   = bus.wr_en && (!full_q || bus.rd_en);
        rd_acc   = bus.rd_en && !empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), MEM_DEPTH));
        if (rd_acc) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), MEM_DEPTH));

        if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
        else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

        // Flags track the next count so they move on the same edge as count.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (bus.wr_en & ~wr_acc);
        udf_d = udf_q | (bus.rd_en & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (bus.dout)
    );
endmodule

// File: tb/tb_fifo_sync_ext.sv
// Purpose : self-checking bench for fifo_sync_ext (depth 16 and depth 5 instances).
// Latency : expects dout one edge after an accepted read.
// Backpressure: exercises write-while-full, read-while-empty and simultaneous cases.
module tb_fifo_sync_ext;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_sync_ext_if #(.DATA_WIDTH(8), .MEM_DEPTH(16)) if16 ();
    fifo_sync_ext_if #(.DATA_WIDTH(8), .MEM_DEPTH(5))  if5 ();

    fifo_sync_ext #(.DATA_WIDTH(8), .MEM_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u16 (
        .clk (clk), .rst (rst), .bus (if16)
    );
    fifo_sync_ext #(.DATA_WIDTH(8), .MEM_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u5 (
        .clk (clk), .rst (rst), .bus (if5)
    );

    // Reference model of the depth-16 FIFO: a queue of stored words plus
    // the last word handed out and the sticky error observations.
    logic [7:0] q16[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_udf  = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic cmp16(input string name, input int idx);
        int n;
        n = q16.size();
        check({name, ".count"}, idx, 32'(if16.count),        32'(n));
        check({name, ".full"},  idx, 32'(if16.full),         32'(n == 16));
        check({name, ".empty"}, idx, 32'(if16.empty),        32'(n == 0));
        check({name, ".af"},    idx, 32'(if16.almost_full),  32'(n >= 14));
        check({name, ".ae"},    idx, 32'(if16.almost_empty), 32'(n <= 2));
        check({name, ".dout"},  idx, 32'(if16.dout),         32'(m_dout));
        check({name, ".ovf"},   idx, 32'(if16.overflow),     32'(ERR_EN && m_ovf));
        check({name, ".udf"},   idx, 32'(if16.underflow),    32'(ERR_EN && m_udf));
    endtask

    task automatic model_reset();
        q16.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // One clock of the depth-16 FIFO: drive, clock, update model, compare.
    task automatic step16(input bit w, input bit r, input logic [7:0] d, input string name, input int idx);
        int sz;
        bit rok;
        bit wok;
        if16.wr_en = w;
        if16.rd_en = r;
        if16.din   = d;
        @(posedge clk);
        #1;
        sz  = q16.size();
        rok = r && (sz > 0);
        wok = w && ((sz < 16) || r);
        if (rok) m_dout = q16.pop_front();
        if (wok) q16.push_back(d);
        if (w && !wok) m_ovf = 1'b1;
        if (r && sz == 0) m_udf = 1'b1;
        cmp16(name, idx);
        if16.wr_en = 1'b0;
        if16.rd_en = 1'b0;
    endtask

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int k;
        bit w;
        bit r;
        logic [7:0] exp;

        if16.wr_en = 1'b0; if16.rd_en = 1'b0; if16.din = 8'h00;
        if5.wr_en  = 1'b0; if5.rd_en  = 1'b0; if5.din  = 8'h00;

        // Depth-5 wrap test: two rounds of 5 writes then 5 reads.
        k = 0;
        for (int rr = 0; rr < 2; rr++) begin
            for (int i = 0; i < 5; i++) begin
                tbl[k].wr = 1'b1; tbl[k].rd = 1'b0;
                tbl[k].din = 8'(8'h40 + rr * 8 + i);
                tbl[k].exp_dout = (rr == 0) ? 8'h00 : 8'h44;
                tbl[k].exp_cnt = i + 1;
                k++;
            end
            for (int i = 0; i < 5; i++) begin
                tbl[k].wr = 1'b0; tbl[k].rd = 1'b1;
                tbl[k].din = 8'h00;
                tbl[k].exp_dout = 8'(8'h40 + rr * 8 + i);
                tbl[k].exp_cnt = 4 - i;
                k++;
            end
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cmp16("reset", 0);
        check("reset5.count", 0, 32'(if5.count), 32'd0);
        check("reset5.ae",    0, 32'(if5.almost_empty), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if5.wr_en = tbl[i].wr;
            if5.rd_en = tbl[i].rd;
            if5.din   = tbl[i].din;
            @(posedge clk);
            #1;
            check("t5.dout",  i, 32'(if5.dout),         32'(tbl[i].exp_dout));
            check("t5.count", i, 32'(if5.count),        32'(tbl[i].exp_cnt));
            check("t5.full",  i, 32'(if5.full),         32'(tbl[i].exp_cnt == 5));
            check("t5.empty", i, 32'(if5.empty),        32'(tbl[i].exp_cnt == 0));
            check("t5.af",    i, 32'(if5.almost_full),  32'(tbl[i].exp_cnt >= 4));
            check("t5.ae",    i, 32'(if5.almost_empty), 32'(tbl[i].exp_cnt <= 1));
            if5.wr_en = 1'b0;
            if5.rd_en = 1'b0;
        end

        // Fill the depth-16 FIFO.
        for (int i = 0; i < 16; i++) step16(1'b1, 1'b0, 8'(8'h10 + i), "fill", i);
        check("full_after_16", 0, 32'(if16.full), 32'd1);

        // Extra write while full is dropped.
        step16(1'b1, 1'b0, 8'hAA, "drop_wr", 0);
        check("ovf_flag", 0, 32'(if16.overflow), 32'(ERR_EN));
        check("drop_count", 0, 32'(if16.count), 32'd16);

        // Simultaneous read and write while full.
        step16(1'b1, 1'b1, 8'h55, "full_rw", 0);
        check("full_rw_dout",  0, 32'(if16.dout),  32'h10);
        check("full_rw_count", 0, 32'(if16.count), 32'd16);
        check("full_rw_full",  0, 32'(if16.full),  32'd1);

        // Drain: 0x11..0x1F then 0x55, never 0xAA.
        for (int i = 0; i < 16; i++) begin
            step16(1'b0, 1'b1, 8'h00, "drain", i);
            exp = (i < 15) ? 8'(8'h11 + i) : 8'h55;
            check("drain_data", i, 32'(if16.dout), 32'(exp));
        end
        check("empty_after_drain", 0, 32'(if16.empty), 32'd1);

        // Read while empty, then read+write while empty.
        step16(1'b0, 1'b1, 8'h00, "empty_rd", 0);
        check("udf_flag",      0, 32'(if16.underflow), 32'(ERR_EN));
        check("empty_rd_dout", 0, 32'(if16.dout),      32'h55);
        step16(1'b1, 1'b1, 8'h33, "empty_rw", 0);
        check("empty_rw_count", 0, 32'(if16.count), 32'd1);
        check("empty_rw_dout",  0, 32'(if16.dout),  32'h55);

        // Random traffic: a write-heavy phase then a read-heavy phase.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step16(w, r, 8'($urandom), "rand", i);
        end

        // Asynchronous reset in the middle of a cycle with data stored.
        for (int i = 0; i < 3; i++) step16(1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst", i);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        cmp16("async_rst", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step16(1'b1, 1'b0, 8'h77, "post_rst_wr", 0);
        step16(1'b0, 1'b1, 8'h00, "post_rst_rd", 0);
        check("post_rst_data", 0, 32'(if16.dout), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_sync_ext.md
# fifo_sync_ext

Parametrised successor to the single-clock FIFO: synchronous first-in first-out buffer with arbitrary (non-power-of-two) depth, an occupancy count output and programmable almost-full/almost-empty thresholds. Optional sticky overflow/underflow error flags are available. It sits between a producer and a consumer in the same clock domain. The registered read data path is the same as the existing FIFO, so current benches and consumers port over unchanged.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- MEM_DEPTH, 16, storage depth in words (≥2, any integer)
- AF_LEVEL, MEM_DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..MEM_DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..MEM_DEPTH-1)
- CW, derived localparam = $clog2(MEM_DEPTH+1), count width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  registered read data
- full  out  1  count == MEM_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  words currently stored
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- The write is accepted on an edge where wr_en=1 and (full=0, or full=1 with rd_en=1). On acceptance, din is stored at wr_ptr and wr_ptr advances.
- The read is accepted on an edge where rd_en=1 and empty=0. On acceptance, mem[rd_ptr] is loaded into dout and rd_ptr advances.
- When no read is accepted, dout holds its last value.
- Pointers range 0..MEM_DEPTH-1 and wrap from MEM_DEPTH-1 to 0 by explicit compare, not by bit overflow.
- count update: +1 if write only, -1 if read only, unchanged if both or neither.
- Full with rd_en=1 and wr_en=1: both are accepted, count stays MEM_DEPTH, and full stays 1.
- Empty with rd_en=1 and wr_en=1: the write is accepted, the read is ignored, count becomes 1, and dout holds.
- Write-while-full without a read: the write is dropped and no pointer or count changes.
- Read-while-empty: the read is ignored and dout holds.
- All flags are registered. Each flag is computed from the next-state count, so a flag changes on the same edge as count.
- No state machine. State is the pointers, count, dout and the error flags.

## Timing
- Read latency is 1 cycle. If rd_en is sampled high at edge N, the data is valid on dout after edge N.
- A write accepted at edge N is readable from edge N+1, since empty deasserts after edge N. There is no read-during-write bypass on the same address.
- Reset values, applied asynchronously on rst:
  - Pointers and count are 0.
  - dout is 0.
  - empty=1 and almost_empty=1. almost_empty is 1 because AE_LEVEL ≥ 0.
  - full, almost_full, overflow and underflow are 0.
  - Memory contents are not reset.
- Asserting rst mid-transfer discards all stored data. The first edge after deassertion behaves as a normal edge.

## Configuration
- FIFO_SYNC_ERR_FLAGS_EN defined:
  - overflow sets on a dropped write and underflow sets on an ignored read.
  - Both flags are sticky until rst.
- Undefined: overflow and underflow are tied to 0 and no flag registers are built. The ports remain, so the instantiation is identical in both builds.

## Structure
- Shared package fifo_pkg holds:
  - The ceiling-log2 constant function used for CW and the pointer widths.
  - The pointer-increment-with-wrap function, reused by future FIFO variants.
- Sub-module fifo_ram is a simple dual-port memory: one write port and one read port with registered output, DATA_WIDTH × MEM_DEPTH. It drives dout directly.
- fifo_sync_ext holds the pointers, count, flags and accept logic.

## Test plan
- MEM_DEPTH=16: write 0x10..0x1F, then read 16 words. Required: dout=0x10..0x1F in order; full=1 after the 16th write; empty=1 after the 16th read.
- Full FIFO: one extra write of 0xAA. Required: dropped, count=16, the subsequent reads contain no 0xAA, overflow=1 with the macro and 0 without.
- Full FIFO, wr_en=rd_en=1 with din=0x55 for 1 cycle. Required: dout=0x10, count=16, and 0x55 is read out 16th.
- MEM_DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: write 5 words and read 5, twice, so the pointers wrap. Required: the data stays in order; almost_full=1 at count 4 and 5; almost_empty=1 at count 0 and 1.
- Empty FIFO: rd_en pulse. Required: dout unchanged and underflow=1 with the macro. Then wr_en=rd_en=1 with din=0x33. Required: count=1 and dout unchanged.
- Write 3 words, then assert rst asynchronously mid-cycle. Required: on rst, immediately count=0, empty=1, almost_empty=1, dout=0 and error flags 0.
